// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus branch target buffer entry layout.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // 2-bit saturating direction counter.
  typedef logic [1:0] btb_ctr_t;

  localparam btb_ctr_t SNT = 2'b00;
  localparam btb_ctr_t WNT = 2'b01;
  localparam btb_ctr_t WT  = 2'b10;
  localparam btb_ctr_t ST  = 2'b11;

  // The tag is kept as a full word holding pc >> (IDXW+2). The upper bits
  // are always zero, so one struct layout serves every ENTRIES setting.
  typedef struct packed {
    logic     valid;
    word_t    tag;
    word_t    target;
    btb_ctr_t ctr;
  } btb_entry_t;

  localparam int unsigned BTB_PENALTY = 2;

endpackage

// File: rtl/sat_counter2.sv
// Next state of a 2-bit saturating branch direction counter.
module sat_counter2
  import cpu_types_pkg::*;
(
  input  btb_ctr_t i_ctr,
  input  logic     i_taken,
  output btb_ctr_t o_ctr
);

  // Taken moves up toward ST, not-taken moves down toward SNT.
  always_comb begin
    o_ctr = i_ctr;
    if (i_taken && (i_ctr != ST)) begin
      o_ctr = i_ctr + 2'd1;
    end else if (!i_taken && (i_ctr != SNT)) begin
      o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: same-cycle fetch prediction, execute-
// stage update, mispredict reporting and saturating statistics.
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PENALTY = BTB_PENALTY
) (
  input  logic        CLK,
  input  logic        nRST,
  input  word_t       lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output word_t       pred_target,
  input  logic        upd_valid,
  input  word_t       upd_pc,
  input  logic        upd_taken,
  input  word_t       upd_target,
  input  logic        upd_pred_taken,
  input  word_t       upd_pred_target,
  input  logic        flush,
  output logic        mispredict,
  output logic [1:0]  penalty_cycles,
  output word_t       stat_branches,
  output word_t       stat_mispred
);

  localparam int unsigned IDXW = $clog2(ENTRIES);

  btb_entry_t r_tab [ENTRIES];
  word_t      r_stat_branches;
  word_t      r_stat_mispred;

  logic [IDXW-1:0] w_lk_idx;
  logic [IDXW-1:0] w_up_idx;
  word_t           w_lk_tag;
  word_t           w_up_tag;
  btb_entry_t      w_lk_ent;
  btb_entry_t      w_up_ent;
  logic            w_up_hit;
  btb_ctr_t        w_ctr_next;

  assign w_lk_idx = lookup_pc[IDXW+1:2];
  assign w_up_idx = upd_pc[IDXW+1:2];
  assign w_lk_tag = lookup_pc >> (IDXW + 2);
  assign w_up_tag = upd_pc >> (IDXW + 2);
  assign w_lk_ent = r_tab[w_lk_idx];
  assign w_up_ent = r_tab[w_up_idx];
  assign w_up_hit = w_up_ent.valid && (w_up_ent.tag == w_up_tag);

  // Zero-latency lookup; reads pre-edge contents, no bypass from updates.
  always_comb begin
    pred_hit    = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag);
    pred_taken  = pred_hit && w_lk_ent.ctr[1];
    pred_target = pred_hit ? w_lk_ent.target : (lookup_pc + 32'd4);
  end

  // Mispredict: wrong direction, or taken both ways but to the wrong target.
  always_comb begin
    mispredict = upd_valid &&
                 ((upd_taken != upd_pred_taken) ||
                  (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    penalty_cycles = mispredict ? PENALTY[1:0] : 2'b00;
  end

  sat_counter2 u_ctr (
    .i_ctr   (w_up_ent.ctr),
    .i_taken (upd_taken),
    .o_ctr   (w_ctr_next)
  );

  // Table state: flush clears valid bits and overrides any same-cycle update.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_tab[i].valid  <= 1'b0;
        r_tab[i].tag    <= '0;
        r_tab[i].target <= '0;
        r_tab[i].ctr    <= WNT;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_tab[i].valid <= 1'b0;
      end
    end else if (upd_valid) begin
      if (w_up_hit) begin
        r_tab[w_up_idx].ctr <= w_ctr_next;
        if (upd_taken) begin
          r_tab[w_up_idx].target <= upd_target;
        end
      end else if (upd_taken) begin
        r_tab[w_up_idx].valid  <= 1'b1;
        r_tab[w_up_idx].tag    <= w_up_tag;
        r_tab[w_up_idx].target <= upd_target;
        r_tab[w_up_idx].ctr    <= WT;
      end
    end
  end

  // Saturating statistics; they keep counting through a flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (upd_valid && (r_stat_branches != '1)) begin
        r_stat_branches <= r_stat_branches + 32'd1;
      end
      if (mispredict && (r_stat_mispred != '1)) begin
        r_stat_mispred <= r_stat_mispred + 32'd1;
      end
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized and directed bench for branch_target_buffer against an
// array-based reference model (ENTRIES=16, PENALTY=2).
module tb_branch_target_buffer;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  word_t       lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  word_t       pred_target;
  logic        upd_valid;
  word_t       upd_pc;
  logic        upd_taken;
  word_t       upd_target;
  logic        upd_pred_taken;
  word_t       upd_pred_target;
  logic        flush;
  logic        mispredict;
  logic [1:0]  penalty_cycles;
  word_t       stat_branches;
  word_t       stat_mispred;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  // Reference model state
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_br;
  logic [31:0] m_mp;

  branch_target_buffer #(
    .ENTRIES (16),
    .PENALTY (2)
  ) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .lookup_pc       (lookup_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .flush           (flush),
    .mispredict      (mispredict),
    .penalty_cycles  (penalty_cycles),
    .stat_branches   (stat_branches),
    .stat_mispred    (stat_mispred)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_br = '0;
    m_mp = '0;
  endtask

  function automatic bit model_mp();
    return upd_valid && ((upd_taken != upd_pred_taken) ||
           (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
  endfunction

  // Applies one clock edge worth of architectural effect using current inputs.
  task automatic model_update();
    int          i;
    logic [31:0] t;
    i = int'((upd_pc >> 2) % 16);
    t = upd_pc >> 6;
    if (upd_valid && (m_br != 32'hFFFF_FFFF)) m_br = m_br + 1;
    if (model_mp() && (m_mp != 32'hFFFF_FFFF)) m_mp = m_mp + 1;
    if (flush) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end else if (upd_valid) begin
      if (m_valid[i] && (m_tag[i] == t)) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1;
        m_tag[i]   = t;
        m_tgt[i]   = upd_target;
        m_ctr[i]   = 2;
      end
    end
  endtask

  task automatic check_outputs();
    int  i;
    bit  hit;
    i   = int'((lookup_pc >> 2) % 16);
    hit = m_valid[i] && (m_tag[i] == (lookup_pc >> 6));
    check("hit",        32'(pred_hit),   32'(hit));
    check("taken",      32'(pred_taken), 32'(hit && (m_ctr[i] >= 2)));
    check("target",     pred_target,     hit ? m_tgt[i] : lookup_pc + 32'd4);
    check("mispredict", 32'(mispredict), 32'(model_mp()));
    check("penalty",    32'(penalty_cycles), model_mp() ? 32'd2 : 32'd0);
    check("stat_br",    stat_branches,   m_br);
    check("stat_mp",    stat_mispred,    m_mp);
  endtask

  task automatic drive(input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic upt, input logic [31:0] uptg,
                       input logic fl, input logic [31:0] lpc);
    upd_valid       = uv;
    upd_pc          = upc;
    upd_taken       = ut;
    upd_target      = utg;
    upd_pred_taken  = upt;
    upd_pred_target = uptg;
    flush           = fl;
    lookup_pc       = lpc;
  endtask

  task automatic tick();
    #2;
    check_outputs();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic idle(input logic [31:0] lpc);
    drive(0, '0, 0, '0, 0, '0, 0, lpc);
  endtask

  initial begin
    nRST = 1'b0;
    idle(32'h40);
    model_reset();
    #23;
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Reset state
    idle(32'h40);
    #1;
    check("rst_hit", 32'(pred_hit), 32'd0);
    check("rst_taken", 32'(pred_taken), 32'd0);
    check("rst_target", pred_target, 32'h44);
    check("rst_stat_br", stat_branches, 32'd0);
    tick();
    idle(32'hFFFF_FFFC);
    #1;
    check("wrap_target", pred_target, 32'h0);
    tick();

    // First allocation with mispredict
    drive(1, 32'h40, 1, 32'h100, 0, 32'h0, 0, 32'h40);
    #1;
    check("alloc_mp", 32'(mispredict), 32'd1);
    check("alloc_pen", 32'(penalty_cycles), 32'd2);
    tick();
    check("alloc_stat_mp", stat_mispred, 32'd1);
    idle(32'h40);
    #1;
    check("alloc_hit", 32'(pred_hit), 32'd1);
    check("alloc_taken", 32'(pred_taken), 32'd1);
    check("alloc_target", pred_target, 32'h100);
    tick();

    // Counter walk: 10 -> 01 -> 00, then up to 11 and saturate
    for (int n = 0; n < 2; n++) begin
      drive(1, 32'h40, 0, 32'h100, n == 0, 32'h100, 0, 32'h40);
      tick();
    end
    idle(32'h40);
    #1;
    check("snt_hit", 32'(pred_hit), 32'd1);
    check("snt_taken", 32'(pred_taken), 32'd0);
    tick();
    for (int n = 0; n < 4; n++) begin
      drive(1, 32'h40, 1, 32'h100, 0, 32'h100, 0, 32'h40);
      tick();
    end
    idle(32'h40);
    #1;
    check("st_taken", 32'(pred_taken), 32'd1);
    tick();

    // Aliasing: 0x440 shares index with 0x40
    drive(1, 32'h440, 1, 32'h300, 0, 32'h0, 0, 32'h40);
    tick();
    idle(32'h40);
    #1;
    check("alias_old_hit", 32'(pred_hit), 32'd0);
    check("alias_old_tgt", pred_target, 32'h44);
    tick();
    idle(32'h440);
    #1;
    check("alias_new_hit", 32'(pred_hit), 32'd1);
    check("alias_new_tgt", pred_target, 32'h300);
    tick();

    // Flush beats a same-cycle allocation
    drive(1, 32'h80, 1, 32'h500, 0, 32'h0, 1, 32'h80);
    tick();
    idle(32'h80);
    #1;
    check("flush_miss", 32'(pred_hit), 32'd0);
    tick();
    idle(32'h440);
    tick();

    // Taken/taken with wrong target
    drive(1, 32'h40, 1, 32'h200, 1, 32'h100, 0, 32'h40);
    #1;
    check("tgt_mp", 32'(mispredict), 32'd1);
    tick();

    // Randomized traffic over a small PC space for frequent hits and aliases
    for (int n = 0; n < 400; n++) begin
      logic [31:0] upc, lpc, utg, uptg;
      logic        ut, upt;
      upc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
      lpc  = ($urandom_range(0, 3) == 0) ? upc :
             ((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2));
      if ($urandom_range(0, 40) == 0) lpc = 32'hFFFF_FFFC;
      utg  = 32'($urandom_range(0, 7)) << 8;
      ut   = 1'($urandom_range(0, 1));
      upt  = 1'($urandom_range(0, 1));
      uptg = ($urandom_range(0, 1) == 0) ? utg : 32'($urandom_range(0, 7)) << 8;
      drive(1'($urandom_range(0, 3) != 0), upc, ut, utg, upt, uptg,
            $urandom_range(0, 19) == 0, lpc);
      tick();
    end

    // Statistics saturation, preloaded close to the top
    dut.r_stat_mispred = 32'hFFFF_FFFD;
    m_mp = 32'hFFFF_FFFD;
    for (int n = 0; n < 4; n++) begin
      drive(1, 32'h40, 1, 32'h100, 0, 32'h0, 0, 32'h40);
      tick();
    end
    check("mp_sat", stat_mispred, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of an update cycle
    drive(1, 32'h40, 1, 32'h100, 0, 32'h0, 0, 32'h40);
    #2;
    nRST = 1'b0;
    #1;
    check("arst_hit", 32'(pred_hit), 32'd0);
    check("arst_target", pred_target, 32'h44);
    check("arst_stat_br", stat_branches, 32'd0);
    check("arst_stat_mp", stat_mispred, 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    idle(32'h40);
    #2;
    nRST = 1'b1;
    tick();
    drive(1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 32'h40);
    tick();
    idle(32'h40);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
